// File: rtl/stage_if.sv
// Instruction fetch stage.
// Owns the PC, issues single-outstanding requests on a simple instruction bus and delivers
// {instruction, address, valid} to if_id through a registered output backed by a one-entry
// skid buffer. A jump pulse from ex redirects the PC and discards any in-flight fetch.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_ex_jump_flag/addr     one-cycle redirect pulse and target from ex
//   i_hold                  downstream stall; o_inst is not taken this cycle
//   o_ibus_req/addr         fetch request and word-aligned address
//   i_ibus_gnt              request accepted this cycle
//   i_ibus_rvalid/rdata     fetch response
//   o_inst/addr/valid       instruction, its address and valid flag to if_id
module stage_if #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_ex_jump_flag,
   input  logic [31:0] i_ex_jump_addr,
   input  logic        i_hold,
   output logic        o_ibus_req,
   output logic [31:0] o_ibus_addr,
   input  logic        i_ibus_gnt,
   input  logic        i_ibus_rvalid,
   input  logic [31:0] i_ibus_rdata,
   output logic [31:0] o_inst,
   output logic [31:0] o_inst_addr,
   output logic        o_inst_valid
);

   typedef enum logic [1:0] {StReset, StReq, StWait, StHold} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] issued_pc_q, issued_pc_d;
   logic        drop_q, drop_d;
   logic [31:0] out_inst_q, out_inst_d;
   logic [31:0] out_addr_q, out_addr_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] skid_inst_q, skid_inst_d;
   logic [31:0] skid_addr_q, skid_addr_d;

   logic consume;
   logic out_free;

   assign consume  = out_valid_q && !i_hold;
   assign out_free = !out_valid_q || consume;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      issued_pc_d = issued_pc_q;
      drop_d      = drop_q;
      out_inst_d  = out_inst_q;
      out_addr_d  = out_addr_q;
      out_valid_d = out_valid_q;
      skid_inst_d = skid_inst_q;
      skid_addr_d = skid_addr_q;

      // A consumed output empties unless refilled below.
      if (consume) begin
         out_inst_d  = NOP_INST;
         out_addr_d  = 32'h0;
         out_valid_d = 1'b0;
      end

      unique case (state_q)
         StReset: state_d = StReq;
         StReq: begin
            if (i_ibus_gnt) begin
               issued_pc_d = pc_q;
               state_d     = StWait;
            end
         end
         StWait: begin
            if (i_ibus_rvalid) begin
               if (drop_q) begin
                  drop_d  = 1'b0;
                  state_d = StReq;
               end else if (out_free) begin
                  out_inst_d  = i_ibus_rdata;
                  out_addr_d  = issued_pc_q;
                  out_valid_d = 1'b1;
                  pc_d        = issued_pc_q + 32'd4;
                  state_d     = StReq;
               end else begin
                  skid_inst_d = i_ibus_rdata;
                  skid_addr_d = issued_pc_q;
                  pc_d        = issued_pc_q + 32'd4;
                  state_d     = StHold;
               end
            end
         end
         StHold: begin
            // The output is always full on entry, so only a consume releases the buffer.
            if (consume) begin
               out_inst_d  = skid_inst_q;
               out_addr_d  = skid_addr_q;
               out_valid_d = 1'b1;
               state_d     = StReq;
            end
         end
         default: state_d = StReset;
      endcase

      // Redirect wins over everything, including hold.
      if (i_ex_jump_flag) begin
         pc_d        = i_ex_jump_addr & 32'hFFFF_FFFC;
         out_inst_d  = NOP_INST;
         out_addr_d  = 32'h0;
         out_valid_d = 1'b0;
         skid_inst_d = NOP_INST;
         skid_addr_d = 32'h0;
         // A request still outstanding after this edge belongs to the old path.
         if ((state_q == StWait && !i_ibus_rvalid) || (state_q == StReq && i_ibus_gnt)) begin
            drop_d  = 1'b1;
            state_d = StWait;
         end else begin
            drop_d  = 1'b0;
            state_d = StReq;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= StReset;
         pc_q        <= RESET_PC;
         issued_pc_q <= RESET_PC;
         drop_q      <= 1'b0;
         out_inst_q  <= NOP_INST;
         out_addr_q  <= 32'h0;
         out_valid_q <= 1'b0;
         skid_inst_q <= NOP_INST;
         skid_addr_q <= 32'h0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         issued_pc_q <= issued_pc_d;
         drop_q      <= drop_d;
         out_inst_q  <= out_inst_d;
         out_addr_q  <= out_addr_d;
         out_valid_q <= out_valid_d;
         skid_inst_q <= skid_inst_d;
         skid_addr_q <= skid_addr_d;
      end
   end

   assign o_ibus_req   = (state_q == StReq);
   assign o_ibus_addr  = pc_q;
   assign o_inst       = out_inst_q;
   assign o_inst_addr  = out_addr_q;
   assign o_inst_valid = out_valid_q;

endmodule

// File: tb/tb_stage_if.sv
module tb_stage_if;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        jf;
   logic [31:0] ja;
   logic        hold;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;

   logic        req,  req2;
   logic [31:0] addr, addr2;
   logic [31:0] inst, inst2;
   logic [31:0] iaddr, iaddr2;
   logic        ivld, ivld2;

   int total = 0;
   int bad   = 0;

   stage_if dut (
      .i_clk(clk), .i_rst(rst), .i_ex_jump_flag(jf), .i_ex_jump_addr(ja), .i_hold(hold),
      .o_ibus_req(req), .o_ibus_addr(addr), .i_ibus_gnt(gnt), .i_ibus_rvalid(rvalid),
      .i_ibus_rdata(rdata), .o_inst(inst), .o_inst_addr(iaddr), .o_inst_valid(ivld)
   );

   // Same stimulus, PC starting at the top of the address space.
   stage_if #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .i_clk(clk), .i_rst(rst), .i_ex_jump_flag(jf), .i_ex_jump_addr(ja), .i_hold(hold),
      .o_ibus_req(req2), .o_ibus_addr(addr2), .i_ibus_gnt(gnt), .i_ibus_rvalid(rvalid),
      .i_ibus_rdata(rdata), .o_inst(inst2), .o_inst_addr(iaddr2), .o_inst_valid(ivld2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; jf = 1'b0; ja = '0; hold = 1'b0; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
      tick();
      tick();
      chk("rst_req",   {31'b0, req},  32'd0);
      chk("rst_addr",  addr,          32'h0);
      chk("rst_inst",  inst,          NOP);
      chk("rst_iaddr", iaddr,         32'h0);
      chk("rst_valid", {31'b0, ivld}, 32'd0);
      chk("rst_addr_wrap", addr2,     32'hFFFF_FFFC);

      // Zero-wait bus after reset release.
      rst = 1'b0;
      chk("c1_no_req", {31'b0, req}, 32'd0);
      tick();
      chk("c2_req",  {31'b0, req}, 32'd1);
      chk("c2_addr", addr,         32'h0);
      chk("c2_addr_wrap", addr2,   32'hFFFF_FFFC);
      gnt = 1'b1;
      tick();
      chk("c3_req_low", {31'b0, req},  32'd0);
      chk("c3_valid",   {31'b0, ivld}, 32'd0);
      gnt = 1'b0; rvalid = 1'b1; rdata = inst_of(32'h0);
      tick();
      chk("c4_valid", {31'b0, ivld}, 32'd1);
      chk("c4_inst",  inst,          inst_of(32'h0));
      chk("c4_iaddr", iaddr,         32'h0);
      chk("c4_addr",  addr,          32'h4);
      chk("c4_addr_wrap", addr2,     32'h0);
      rvalid = 1'b0; gnt = 1'b1;
      tick();
      chk("c5_valid_low", {31'b0, ivld}, 32'd0);
      gnt = 1'b0; rvalid = 1'b1; rdata = inst_of(32'h4);
      tick();
      chk("c6_valid", {31'b0, ivld}, 32'd1);
      chk("c6_iaddr", iaddr,         32'h4);
      chk("c6_addr",  addr,          32'h8);

      // Hold for 6 cycles while inst@8 returns.
      rvalid = 1'b0; hold = 1'b1; gnt = 1'b1;
      tick();
      gnt = 1'b0; rvalid = 1'b1; rdata = inst_of(32'h8);
      tick();
      rvalid = 1'b0;
      chk("hold_no_req", {31'b0, req}, 32'd0);
      chk("hold_iaddr",  iaddr,        32'h4);
      chk("hold_valid",  {31'b0, ivld}, 32'd1);
      tick();
      tick();
      tick();
      chk("hold_no_req_late", {31'b0, req}, 32'd0);
      chk("hold_inst_late",   inst,         inst_of(32'h4));
      tick();
      hold = 1'b0;
      tick();
      chk("unhold_valid", {31'b0, ivld}, 32'd1);
      chk("unhold_inst",  inst,          inst_of(32'h8));
      chk("unhold_iaddr", iaddr,         32'h8);
      chk("unhold_req",   {31'b0, req},  32'd1);
      chk("unhold_addr",  addr,          32'hC);
      gnt = 1'b1;
      tick();
      gnt = 1'b0;
      chk("wait12_valid", {31'b0, ivld}, 32'd0);

      // Jump while waiting; late response must be dropped.
      jf = 1'b1; ja = 32'h100;
      tick();
      jf = 1'b0;
      chk("jw_no_req", {31'b0, req},  32'd0);
      tick();
      rvalid = 1'b1; rdata = inst_of(32'hC);
      tick();
      rvalid = 1'b0;
      chk("jw_dropped", {31'b0, ivld}, 32'd0);
      chk("jw_req",     {31'b0, req},  32'd1);
      chk("jw_addr",    addr,          32'h100);
      gnt = 1'b1;
      tick();
      gnt = 1'b0; rvalid = 1'b1; rdata = inst_of(32'h100);
      tick();
      rvalid = 1'b0;
      chk("jw_valid", {31'b0, ivld}, 32'd1);
      chk("jw_inst",  inst,          inst_of(32'h100));
      chk("jw_iaddr", iaddr,         32'h100);
      chk("jw_next",  addr,          32'h104);

      // Jump coincident with rvalid under hold.
      hold = 1'b1; gnt = 1'b1;
      tick();
      gnt = 1'b0; rvalid = 1'b1; rdata = inst_of(32'h104); jf = 1'b1; ja = 32'h203;
      tick();
      rvalid = 1'b0; jf = 1'b0; hold = 1'b0;
      chk("jr_inst",  inst,          NOP);
      chk("jr_valid", {31'b0, ivld}, 32'd0);
      chk("jr_iaddr", iaddr,         32'h0);
      chk("jr_req",   {31'b0, req},  32'd1);
      chk("jr_addr",  addr,          32'h200);
      gnt = 1'b1;
      tick();
      gnt = 1'b0; rvalid = 1'b1; rdata = inst_of(32'h200);
      tick();
      rvalid = 1'b0;
      chk("jr_fetch_valid", {31'b0, ivld}, 32'd1);
      chk("jr_fetch_iaddr", iaddr,         32'h200);

      // Request without grant holds its address; a jump retargets it.
      tick();
      chk("nogrant_addr", addr, 32'h204);
      jf = 1'b1; ja = 32'h300;
      tick();
      jf = 1'b0;
      chk("retarget_req",  {31'b0, req}, 32'd1);
      chk("retarget_addr", addr,         32'h300);

      // Reset in the middle of a fetch, then a late response.
      gnt = 1'b1;
      tick();
      gnt = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0; rvalid = 1'b1; rdata = inst_of(32'h300);
      chk("mid_rst_req",  {31'b0, req}, 32'd0);
      chk("mid_rst_addr", addr,         32'h0);
      tick();
      rvalid = 1'b0;
      chk("late_rv_valid", {31'b0, ivld}, 32'd0);
      chk("late_rv_inst",  inst,          NOP);
      chk("refetch_req",   {31'b0, req},  32'd1);
      chk("refetch_addr",  addr,          32'h0);
      gnt = 1'b1;
      tick();
      gnt = 1'b0; rvalid = 1'b1; rdata = inst_of(32'h0);
      tick();
      rvalid = 1'b0;
      chk("refetch_valid", {31'b0, ivld}, 32'd1);
      chk("refetch_inst",  inst,          inst_of(32'h0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
